// File: rtl/color_seq_pkg.sv
// Shared command/mode encodings and colour-code helper for the colour sequencer.
package color_seq_pkg;

    localparam int unsigned CMD_WIDTH = 2;

    typedef enum logic [CMD_WIDTH-1:0] {
        CMD_HOLD    = 2'h0,
        CMD_ADVANCE = 2'h1,
        CMD_JUMP    = 2'h2,
        CMD_AUTO    = 2'h3
    } cmd_t;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_t;

    // Colour code shown for a state index; callers truncate to their output width.
    function automatic logic [31:0] color_code(input logic [31:0] idx);
        return idx + 32'd1;
    endfunction

endpackage

// File: rtl/color_seq_if.sv
// Command/status bundle between the command decoder and the colour sequencer.
interface color_seq_if #(
    parameter int unsigned NUM_STATES  = 4,
    parameter int unsigned OUT_WIDTH   = 4,
    parameter int unsigned DWELL_WIDTH = 8
) ();
    import color_seq_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_STATES);

    cmd_t                   in;
    logic [IDX_W-1:0]       jump_idx;
    logic [DWELL_WIDTH-1:0] dwell_cfg;
    logic [OUT_WIDTH-1:0]   out;
    logic [IDX_W-1:0]       state;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic                   wrap;
    logic                   err;

    modport master (
        output in, jump_idx, dwell_cfg,
        input  out, state, dwell_cnt, wrap, err
    );

    modport slave (
        input  in, jump_idx, dwell_cfg,
        output out, state, dwell_cnt, wrap, err
    );

endinterface

// File: rtl/color_dwell_timer.sv
// Dwell counter for AUTO mode: counts cycles in the current state and flags expiry.
module color_dwell_timer #(
    parameter int unsigned DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic [DWELL_WIDTH-1:0] dwell_cfg_i,
    output logic [DWELL_WIDTH-1:0] dwell_cnt_o,
    output logic                   expire_c
);

    logic [DWELL_WIDTH-1:0] cnt_q;
    logic [DWELL_WIDTH-1:0] cnt_d;
    logic [DWELL_WIDTH-1:0] base_c;

    // Clear restarts from zero; >= keeps a lowered dwell_cfg from letting the count run past it.
    always_comb begin
        base_c   = clear_i ? '0 : cnt_q;
        expire_c = enable_i && (base_c >= dwell_cfg_i);
        cnt_d    = (!enable_i || expire_c) ? '0 : base_c + DWELL_WIDTH'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign dwell_cnt_o = cnt_q;

endmodule

// File: rtl/color_seq_fsm.sv
// Parametrised Moore colour sequencer with manual advance, indexed jump and timed auto-advance.
module color_seq_fsm
    import color_seq_pkg::*;
#(
    parameter int unsigned NUM_STATES  = 4,
    parameter int unsigned OUT_WIDTH   = 4,
    parameter int unsigned DWELL_WIDTH = 8,
    parameter int unsigned RESET_STATE = 1
) (
    input  logic      clk,
    input  logic      rst,
    color_seq_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_STATES);
    localparam logic [IDX_W:0]   NS_W     = (IDX_W+1)'(NUM_STATES);
    localparam logic [IDX_W-1:0] RST_IDX  = IDX_W'(RESET_STATE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATES - 1);

    logic [IDX_W-1:0] state_q, state_d;
    mode_t            mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [IDX_W:0]   inc_c;
    logic [IDX_W-1:0] next_idx_c;
    logic             illegal_c;
    logic             tmr_clear_c, tmr_enable_c, tmr_expire_c;

    // Successor index computed one bit wider so non-power-of-two wrap is exact.
    always_comb begin
        inc_c      = {1'b0, state_q} + (IDX_W+1)'(1);
        next_idx_c = (inc_c >= NS_W) ? '0 : inc_c[IDX_W-1:0];
        illegal_c  = ({1'b0, state_q} >= NS_W);
    end

    assign tmr_enable_c = (bus.in == CMD_AUTO) && !illegal_c;
    assign tmr_clear_c  = (mode_q == MODE_MANUAL);

    color_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (tmr_clear_c),
        .enable_i    (tmr_enable_c),
        .dwell_cfg_i (bus.dwell_cfg),
        .dwell_cnt_o (bus.dwell_cnt),
        .expire_c    (tmr_expire_c)
    );

    // Next state, mode and status pulses; any non-AUTO command drops back to MANUAL.
    always_comb begin
        state_d = state_q;
        mode_d  = MODE_MANUAL;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (illegal_c) begin
            state_d = RST_IDX;
            err_d   = 1'b1;
        end else begin
            case (bus.in)
                CMD_HOLD: begin
                    state_d = state_q;
                end
                CMD_ADVANCE: begin
                    state_d = next_idx_c;
                    wrap_d  = (state_q == LAST_IDX);
                end
                CMD_JUMP: begin
                    if ({1'b0, bus.jump_idx} < NS_W) state_d = bus.jump_idx;
                    else                             err_d   = 1'b1;
                end
                CMD_AUTO: begin
                    mode_d = MODE_AUTO;
                    if (tmr_expire_c) begin
                        state_d = next_idx_c;
                        wrap_d  = (state_q == LAST_IDX);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, mode and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RST_IDX;
            mode_q  <= MODE_MANUAL;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.out   = OUT_WIDTH'(color_code(32'(state_q)));
    assign bus.state = state_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_color_seq_fsm.sv
// Self-checking bench for color_seq_fsm: three builds (4, 3 and 5 states) with a scoreboard model.
module tb_color_seq_fsm;
    import color_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst3, rst5;

    color_seq_if #(.NUM_STATES(4), .OUT_WIDTH(4), .DWELL_WIDTH(8)) bus4 ();
    color_seq_if #(.NUM_STATES(3), .OUT_WIDTH(4), .DWELL_WIDTH(8)) bus3 ();
    color_seq_if #(.NUM_STATES(5), .OUT_WIDTH(4), .DWELL_WIDTH(8)) bus5 ();

    color_seq_fsm #(.NUM_STATES(4), .OUT_WIDTH(4), .DWELL_WIDTH(8), .RESET_STATE(1))
        dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    color_seq_fsm #(.NUM_STATES(3), .OUT_WIDTH(4), .DWELL_WIDTH(8), .RESET_STATE(1))
        dut3 (.clk(clk), .rst(rst3), .bus(bus3));
    color_seq_fsm #(.NUM_STATES(5), .OUT_WIDTH(4), .DWELL_WIDTH(8), .RESET_STATE(1))
        dut5 (.clk(clk), .rst(rst5), .bus(bus5));

    typedef struct {
        string tag;
        int    st;
        int    out;
        int    wrap;
        int    err;
        int    cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   ns[3]     = '{4, 3, 5};
    int   m_st[3]   = '{1, 1, 1};
    int   m_cnt[3]  = '{0, 0, 0};
    int   m_auto[3] = '{0, 0, 0};
    bit   r[3]      = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour for one clock of DUT k.
    task automatic model(input int k, input bit rv, input cmd_t c, input int j, input int cfg,
                         output exp_t e);
        int n;
        int w;
        int er;
        int base;
        n  = ns[k];
        w  = 0;
        er = 0;
        if (!rv) begin
            m_st[k] = 1; m_cnt[k] = 0; m_auto[k] = 0;
        end else if (m_st[k] >= n) begin
            m_st[k] = 1; m_cnt[k] = 0; m_auto[k] = 0; er = 1;
        end else begin
            case (c)
                CMD_HOLD: begin
                    m_cnt[k] = 0; m_auto[k] = 0;
                end
                CMD_ADVANCE: begin
                    w = (m_st[k] == n - 1) ? 1 : 0;
                    m_st[k] = (m_st[k] + 1) % n;
                    m_cnt[k] = 0; m_auto[k] = 0;
                end
                CMD_JUMP: begin
                    if (j < n) m_st[k] = j;
                    else       er = 1;
                    m_cnt[k] = 0; m_auto[k] = 0;
                end
                default: begin
                    base = (m_auto[k] != 0) ? m_cnt[k] : 0;
                    if (base >= cfg) begin
                        w = (m_st[k] == n - 1) ? 1 : 0;
                        m_st[k] = (m_st[k] + 1) % n;
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = base + 1;
                    end
                    m_auto[k] = 1;
                end
            endcase
        end
        e.tag  = "";
        e.st   = m_st[k];
        e.out  = (m_st[k] + 1) % 16;
        e.wrap = w;
        e.err  = er;
        e.cnt  = m_cnt[k];
    endtask

    task automatic drive(input int k, input bit rv, input cmd_t c, input int j, input int cfg);
        case (k)
            0: begin rst4 = rv; bus4.in = c; bus4.jump_idx = 2'(j); bus4.dwell_cfg = 8'(cfg); end
            1: begin rst3 = rv; bus3.in = c; bus3.jump_idx = 2'(j); bus3.dwell_cfg = 8'(cfg); end
            default: begin rst5 = rv; bus5.in = c; bus5.jump_idx = 3'(j); bus5.dwell_cfg = 8'(cfg); end
        endcase
    endtask

    task automatic compare(input int k);
        exp_t e;
        logic [31:0] st, out, wrap, err, cnt;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
            return;
        end
        e = sb.pop_front();
        case (k)
            0: begin st = 32'(bus4.state); out = 32'(bus4.out); wrap = 32'(bus4.wrap);
                     err = 32'(bus4.err); cnt = 32'(bus4.dwell_cnt); end
            1: begin st = 32'(bus3.state); out = 32'(bus3.out); wrap = 32'(bus3.wrap);
                     err = 32'(bus3.err); cnt = 32'(bus3.dwell_cnt); end
            default: begin st = 32'(bus5.state); out = 32'(bus5.out); wrap = 32'(bus5.wrap);
                     err = 32'(bus5.err); cnt = 32'(bus5.dwell_cnt); end
        endcase
        check({e.tag, "_state"}, st,   32'(e.st));
        check({e.tag, "_out"},   out,  32'(e.out));
        check({e.tag, "_wrap"},  wrap, 32'(e.wrap));
        check({e.tag, "_err"},   err,  32'(e.err));
        check({e.tag, "_dwell"}, cnt,  32'(e.cnt));
    endtask

    // One clock: DUT id gets the command, the others idle on HOLD at their current reset level.
    task automatic step(input int id, input bit rv, input cmd_t c, input int j, input int cfg,
                        input string tag);
        exp_t e;
        r[id] = rv;
        for (int k = 0; k < 3; k++) begin
            if (k == id) begin
                drive(k, rv, c, j, cfg);
                model(k, rv, c, j, cfg, e);
                e.tag = tag;
                sb.push_back(e);
            end else begin
                drive(k, r[k], CMD_HOLD, 0, 0);
                model(k, r[k], CMD_HOLD, 0, 0, e);
            end
        end
        @(posedge clk);
        #1;
        compare(id);
    endtask

    initial begin
        int exp_seq[4];
        int exp_dw[6];
        int wraps;
        cmd_t c;
        exp_seq = '{2, 3, 0, 1};
        exp_dw  = '{1, 2, 0, 1, 2, 0};
        for (int k = 0; k < 3; k++) drive(k, 1'b0, CMD_HOLD, 0, 0);

        // Reset then idle HOLD.
        for (int i = 0; i < 2; i++) begin
            step(0, 1'b0, CMD_HOLD, 0, 0, "t1_rst4");
            step(1, 1'b0, CMD_HOLD, 0, 0, "t1_rst3");
            step(2, 1'b0, CMD_HOLD, 0, 0, "t1_rst5");
        end
        check("t1_reset_out", 32'(bus4.out), 32'd2);
        step(1, 1'b1, CMD_HOLD, 0, 0, "t1_rel3");
        step(2, 1'b1, CMD_HOLD, 0, 0, "t1_rel5");
        for (int i = 0; i < 10; i++) step(0, 1'b1, CMD_HOLD, 0, 0, "t1_hold");
        check("t1_state", 32'(bus4.state), 32'd1);

        // ADVANCE x4 with a single wrap pulse on 3 -> 0.
        wraps = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, CMD_ADVANCE, 0, 0, "t2_adv");
            check("t2_seq", 32'(bus4.state), 32'(exp_seq[i]));
            if (bus4.wrap === 1'b1) wraps++;
        end
        check("t2_wrap_count", 32'(wraps), 32'd1);

        // Legal and illegal jumps; JUMP to 0 never wraps.
        step(0, 1'b1, CMD_JUMP, 3, 0, "t3_jump3");
        check("t3_out4", 32'(bus4.out), 32'd4);
        step(1, 1'b1, CMD_ADVANCE, 0, 0, "t3_adv3");
        step(1, 1'b1, CMD_JUMP, 3, 0, "t3_illegal");
        check("t3_illegal_err", 32'(bus3.err), 32'd1);
        step(1, 1'b1, CMD_HOLD, 0, 0, "t3_err_clear");
        step(0, 1'b1, CMD_JUMP, 0, 0, "t3_jump0");

        // AUTO dwell 2, then dwell 0, then a mid-dwell cfg reduction.
        for (int i = 0; i < 6; i++) begin
            step(0, 1'b1, CMD_AUTO, 0, 2, "t4_auto2");
            check("t4_dwell_seq", 32'(bus4.dwell_cnt), 32'(exp_dw[i]));
        end
        check("t4_state_after6", 32'(bus4.state), 32'd2);
        for (int i = 0; i < 3; i++) step(0, 1'b1, CMD_AUTO, 0, 0, "t4_auto0");
        for (int i = 0; i < 3; i++) step(0, 1'b1, CMD_AUTO, 0, 5, "t4_auto5");
        step(0, 1'b1, CMD_AUTO, 0, 1, "t4_cfgdrop");
        step(0, 1'b1, CMD_HOLD, 0, 0, "t4_hold");

        // Exit AUTO with no pending advance; reset mid-AUTO.
        step(0, 1'b1, CMD_AUTO, 0, 2, "t5_auto");
        step(0, 1'b1, CMD_HOLD, 0, 2, "t5_hold");
        step(0, 1'b1, CMD_AUTO, 0, 3, "t5_auto_b");
        step(0, 1'b1, CMD_AUTO, 0, 3, "t5_auto_c");
        step(0, 1'b0, CMD_AUTO, 0, 3, "t5_rst");
        check("t5_mode", 32'(dut4.mode_q), 32'(MODE_MANUAL));
        check("t5_rst_state", 32'(bus4.state), 32'd1);
        step(0, 1'b1, CMD_HOLD, 0, 0, "t5_idle");

        // Illegal state recovery on the 5-state build.
        step(2, 1'b1, CMD_ADVANCE, 0, 0, "t6_pre");
        force dut5.state_q = 3'd7;
        #1;
        release dut5.state_q;
        check("t6_forced", 32'(bus5.state), 32'd7);
        m_st[2] = 7;
        step(2, 1'b1, CMD_ADVANCE, 0, 0, "t6_recover");
        check("t6_rec_state", 32'(bus5.state), 32'd1);
        check("t6_rec_err", 32'(bus5.err), 32'd1);

        // Random soak on both even and odd state counts.
        for (int i = 0; i < 150; i++) begin
            c = cmd_t'($urandom_range(0, 3));
            step(0, ($urandom_range(0, 29) != 0), c, $urandom_range(0, 3),
                 $urandom_range(0, 3), "soak4");
        end
        step(0, 1'b1, CMD_HOLD, 0, 0, "soak4_end");
        for (int i = 0; i < 150; i++) begin
            c = cmd_t'($urandom_range(0, 3));
            step(2, ($urandom_range(0, 29) != 0), c, $urandom_range(0, 7),
                 $urandom_range(0, 3), "soak5");
            check("soak5_range", 32'(bus5.state < 3'd5), 32'd1);
        end
        step(2, 1'b1, CMD_HOLD, 0, 0, "soak5_end");

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
